// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter and its on-chip checker: checker
// states and the single next-count rule both sides evaluate.
package counter_pkg;

  // The step rule is evaluated at this width; callers zero-extend and truncate.
  localparam int CNT_MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAIL  = 2'd2
  } chk_state_e;

  function automatic logic [CNT_MAX_W-1:0] next_count(
    input logic [CNT_MAX_W-1:0] m,
    input logic                 load,
    input logic [CNT_MAX_W-1:0] load_value,
    input logic                 enable,
    input logic                 up_down,
    input logic [CNT_MAX_W-1:0] max_count
  );
    if (load)
      return load_value;
    if (enable && up_down)
      return (m >= max_count) ? '0 : m + CNT_MAX_W'(1);
    if (enable)
      return (m == '0) ? max_count : m - CNT_MAX_W'(1);
    return m;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; sticks at all-ones
// instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst || clr)
      value <= '0;
    else if (inc && (value != '1))
      value <= value + W'(1);
  end

endmodule

// File: rtl/counter_checker.sv
// Cycle-accurate monitor for the programmable up/down counter: runs a shadow
// model in lockstep, flags mismatches one cycle later and keeps statistics.
module counter_checker
  import counter_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int ERR_CNT_W   = 16,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arm,
  input  logic                 load,
  input  logic                 enable,
  input  logic                 up_down,
  input  logic [WIDTH-1:0]     load_value,
  input  logic [WIDTH-1:0]     max_count,
  input  logic [WIDTH-1:0]     obs_count,
  input  logic                 obs_tc,
  input  logic                 obs_zero,
  output logic [1:0]           state,
  output logic                 err_pulse,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [ERR_CNT_W-1:0] chk_count,
  output logic [WIDTH-1:0]     first_bad
);

  chk_state_e       st;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] m_next;
  logic             tracking;
  logic             exp_zero;
  logic             exp_tc;
  logic             mismatch;

  assign tracking = (st == TRACK);
  assign exp_zero = (m == '0);
  assign exp_tc   = up_down ? (m == max_count) : exp_zero;
  assign mismatch = tracking &&
                    ((obs_count != m) || (obs_tc != exp_tc) || (obs_zero != exp_zero));

  assign m_next = WIDTH'(next_count(CNT_MAX_W'(m), load, CNT_MAX_W'(load_value),
                                    enable, up_down, CNT_MAX_W'(max_count)));

  assign state = st;

  // arm outranks any compare in the same cycle, so an armed cycle never logs an error.
  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= IDLE;
      m          <= '0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      first_bad  <= '0;
    end else if (arm) begin
      st         <= TRACK;
      m          <= obs_count;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      first_bad  <= '0;
    end else begin
      err_pulse <= mismatch;
      if (mismatch) begin
        err_sticky <= 1'b1;
        if (!err_sticky)
          first_bad <= obs_count;
        if (STOP_ON_ERR)
          st <= FAIL;
        else
          m <= obs_count;
      end else if (tracking) begin
        m <= m_next;
      end
    end
  end

  sat_counter #(.W(ERR_CNT_W)) u_err_count (
    .clk   (clk),
    .rst   (rst),
    .clr   (arm),
    .inc   (mismatch),
    .value (err_count)
  );

  sat_counter #(.W(ERR_CNT_W)) u_chk_count (
    .clk   (clk),
    .rst   (rst),
    .clr   (arm),
    .inc   (tracking),
    .value (chk_count)
  );

endmodule
